// File: rtl/fx2lp_stream_in_writer.sv
// FX2LP slave-FIFO stream-IN writer: buffers upstream or counter-pattern words in a FWFT FIFO
// and drains them to the endpoint under FLAG flow control, with PKTEND on flush.
module fx2lp_stream_in_writer #(
  parameter int         DATA_W    = 16,
  parameter int         DEPTH     = 16,
  parameter int         PKT_WORDS = 256,
  parameter logic [1:0] EP_ADDR   = 2'b10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              mode,
  input  logic              flush,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              flag_nf,
  output logic [DATA_W-1:0] fdata,
  output logic [1:0]        faddr,
  output logic              slwr_n,
  output logic              slrd_n,
  output logic              sloe_n,
  output logic              pktend_n,
  output logic              busy,
  output logic [9:0]        pkt_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, FLUSH, PKTEND} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DATA_W-1:0] fdata_q, fdata_d, pat_q, pat_d;
  logic [9:0]        pkt_cnt_q, pkt_cnt_d;
  logic              flush_pend_q, flush_pend_d;
  state_t            state_q, state_d;
  logic              empty, full, pop, push, room, pend_clr;
  logic [DATA_W-1:0] push_data;

  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == (AW+1)'(DEPTH));
    pop       = (state_q == WRITE) && flag_nf && !empty;
    // A pop in the same cycle frees a slot, so a full buffer can still accept a word.
    room      = !full || pop;
    push      = mode ? (room && enable) : (s_valid && room);
    push_data = mode ? pat_q : s_data;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    pat_d    = (mode && push) ? pat_q + DATA_W'(1) : pat_q;

    // Head register: next stored word after a pop, the incoming word when the
    // buffer would otherwise be empty, else hold the current head.
    fdata_d = fdata_q;
    if (count_q == (AW+1)'(pop)) begin
      if (push) fdata_d = push_data;
    end else if (pop) begin
      fdata_d = mem[rd_ptr_d];
    end

    pkt_cnt_d = pkt_cnt_q;
    if (state_q == PKTEND)
      pkt_cnt_d = '0;
    else if (pop)
      pkt_cnt_d = (pkt_cnt_q == 10'(PKT_WORDS - 1)) ? '0 : pkt_cnt_q + 10'd1;

    pend_clr     = ((state_q == FLUSH) && (pkt_cnt_q == '0)) || (state_q == PKTEND);
    flush_pend_d = pend_clr ? 1'b0 : (flush_pend_q || flush);

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!empty && flag_nf && (enable || flush_pend_q)) state_d = WRITE;
        else if (empty && flush_pend_q)                    state_d = FLUSH;
      end
      WRITE: begin
        if (empty && flush_pend_q)                              state_d = FLUSH;
        else if (empty || !flag_nf || (!enable && !flush_pend_q)) state_d = IDLE;
      end
      FLUSH: begin
        if (pkt_cnt_q == '0) state_d = IDLE;
        else if (flag_nf)    state_d = PKTEND;
      end
      PKTEND:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      fdata_q      <= '0;
      pat_q        <= '0;
      pkt_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      state_q      <= IDLE;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fdata_q      <= fdata_d;
      pat_q        <= pat_d;
      pkt_cnt_q    <= pkt_cnt_d;
      flush_pend_q <= flush_pend_d;
      state_q      <= state_d;
    end
  end

  assign s_ready  = reset_n && !mode && room;
  assign fdata    = fdata_q;
  assign faddr    = EP_ADDR;
  assign slwr_n   = !pop;
  assign slrd_n   = 1'b1;
  assign sloe_n   = 1'b1;
  assign pktend_n = (state_q != PKTEND);
  assign busy     = (state_q != IDLE) || !empty;
  assign pkt_cnt  = pkt_cnt_q;
endmodule

// File: tb/tb_fx2lp_stream_in_writer.sv
// Directed self-checking bench for fx2lp_stream_in_writer with default parameters.
module tb_fx2lp_stream_in_writer;
  logic        clk = 1'b0;
  logic        reset_n, enable, mode, flush, s_valid, flag_nf;
  logic [15:0] s_data;
  logic        s_ready, slwr_n, slrd_n, sloe_n, pktend_n, busy;
  logic [15:0] fdata;
  logic [1:0]  faddr;
  logic [9:0]  pkt_cnt;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_pktend = 0;
  logic [15:0] wr_q[$];

  always #5 clk = ~clk;

  fx2lp_stream_in_writer dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode), .flush(flush),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .flag_nf(flag_nf),
    .fdata(fdata), .faddr(faddr), .slwr_n(slwr_n), .slrd_n(slrd_n), .sloe_n(sloe_n),
    .pktend_n(pktend_n), .busy(busy), .pkt_cnt(pkt_cnt)
  );

  // One clock cycle: record any write / packet-end strobe seen before the edge.
  task automatic step();
    #1;
    if (slwr_n === 1'b0) wr_q.push_back(fdata);
    if (pktend_n === 1'b0) n_pktend++;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; mode = 1'b0; enable = 1'b0; flush = 1'b0;
    s_valid = 1'b0; s_data = '0; flag_nf = 1'b1;
    step(); step();
    reset_n = 1'b1;
    wr_q.delete();
    n_pktend = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; mode = 1'b0; enable = 1'b1; flush = 1'b0;
    s_valid = 1'b1; s_data = 16'h1234; flag_nf = 1'b1;
    step(); step();
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    n_cmp++; if (slwr_n !== 1'b1) begin n_bad++; $display("FAIL reset_slwr_n: got %b want 1", slwr_n); end
    n_cmp++; if (pktend_n !== 1'b1) begin n_bad++; $display("FAIL reset_pktend_n: got %b want 1", pktend_n); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (pkt_cnt !== 10'd0) begin n_bad++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
    n_cmp++; if (fdata !== 16'h0000) begin n_bad++; $display("FAIL reset_fdata: got %h want 0000", fdata); end
    n_cmp++; if (faddr !== 2'b10) begin n_bad++; $display("FAIL reset_faddr: got %b want 10", faddr); end
    n_cmp++; if (slrd_n !== 1'b1 || sloe_n !== 1'b1) begin n_bad++; $display("FAIL reset_slrd_sloe: got %b%b want 11", slrd_n, sloe_n); end
    s_valid = 1'b0; enable = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_counter_mode();
    do_reset();
    mode = 1'b1; enable = 1'b1; flag_nf = 1'b1;
    for (int c = 0; c < 600; c++) begin
      #1;
      n_cmp++;
      if (pkt_cnt !== 10'(wr_q.size() % 256)) begin
        n_bad++; $display("FAIL counter_pkt_cnt cycle %0d: got %0d want %0d", c, pkt_cnt, wr_q.size() % 256);
      end
      step();
    end
    mode = 1'b0; enable = 1'b0;
    n_cmp++; if (wr_q.size() != 598) begin n_bad++; $display("FAIL counter_nwrites: got %0d want 598", wr_q.size()); end
    for (int i = 0; i < wr_q.size(); i++) begin
      n_cmp++;
      if (wr_q[i] !== 16'(i)) begin n_bad++; $display("FAIL counter_data[%0d]: got %h want %h", i, wr_q[i], 16'(i)); end
    end
    n_cmp++; if (n_pktend != 0) begin n_bad++; $display("FAIL counter_pktend: got %0d want 0", n_pktend); end
    $display("counter_mode: %0d words written", wr_q.size());
  endtask

  task automatic test_flush_partial();
    int pktend_at;
    do_reset();
    enable = 1'b1; flag_nf = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = 16'hA000 + 16'(i);
      #1;
      n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL flush_s_ready[%0d]: got %b want 1", i, s_ready); end
      step();
    end
    s_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    pktend_at = -1;
    for (int g = 0; g < 20; g++) begin
      #1;
      if (pktend_n === 1'b0 && pktend_at < 0) pktend_at = wr_q.size();
      step();
    end
    #1;
    n_cmp++; if (wr_q.size() != 10) begin n_bad++; $display("FAIL flush_nwrites: got %0d want 10", wr_q.size()); end
    for (int i = 0; i < wr_q.size() && i < 10; i++) begin
      n_cmp++;
      if (wr_q[i] !== 16'hA000 + 16'(i)) begin n_bad++; $display("FAIL flush_data[%0d]: got %h want %h", i, wr_q[i], 16'hA000 + 16'(i)); end
    end
    n_cmp++; if (n_pktend != 1) begin n_bad++; $display("FAIL flush_pktend_cycles: got %0d want 1", n_pktend); end
    n_cmp++; if (pktend_at != 10) begin n_bad++; $display("FAIL flush_pktend_after: got %0d want 10", pktend_at); end
    n_cmp++; if (pkt_cnt !== 10'd0) begin n_bad++; $display("FAIL flush_pkt_cnt: got %0d want 0", pkt_cnt); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b want 0", busy); end
    $display("flush_partial: %0d words, %0d pktend cycles", wr_q.size(), n_pktend);
    enable = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    enable = 1'b0; flag_nf = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 16'hC000 + 16'(i);
      step();
    end
    s_valid = 1'b0;
    enable = 1'b1;
    for (int g = 0; g < 20 && wr_q.size() < 3; g++) step();
    flag_nf = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (slwr_n !== 1'b1) begin n_bad++; $display("FAIL stall_slwr_n[%0d]: got %b want 1", k, slwr_n); end
      step();
    end
    n_cmp++; if (wr_q.size() != 3) begin n_bad++; $display("FAIL stall_writes_before: got %0d want 3", wr_q.size()); end
    flag_nf = 1'b1;
    for (int g = 0; g < 20; g++) step();
    n_cmp++; if (wr_q.size() != 8) begin n_bad++; $display("FAIL stall_nwrites: got %0d want 8", wr_q.size()); end
    for (int i = 0; i < wr_q.size() && i < 8; i++) begin
      n_cmp++;
      if (wr_q[i] !== 16'hC000 + 16'(i)) begin n_bad++; $display("FAIL stall_data[%0d]: got %h want %h", i, wr_q[i], 16'hC000 + 16'(i)); end
    end
    $display("stall: %0d words written", wr_q.size());
    enable = 1'b0;
  endtask

  task automatic test_full();
    do_reset();
    enable = 1'b1; flag_nf = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 16'hB000 + 16'(i);
      #1;
      n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL full_fill_ready[%0d]: got %b want 1", i, s_ready); end
      step();
    end
    s_data = 16'hB010;
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL full_s_ready: got %b want 0", s_ready); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL full_busy: got %b want 1", busy); end
    step();
    flag_nf = 1'b1;
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL full_idle_ready: got %b want 0", s_ready); end
    step();
    #1;
    n_cmp++; if (slwr_n !== 1'b0) begin n_bad++; $display("FAIL full_pop_slwr_n: got %b want 0", slwr_n); end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL full_pushpop_ready: got %b want 1", s_ready); end
    step();
    s_valid = 1'b0; flag_nf = 1'b0;
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL full_still_full: got %b want 0", s_ready); end
    step();
    flag_nf = 1'b1;
    for (int g = 0; g < 40; g++) step();
    n_cmp++; if (wr_q.size() != 17) begin n_bad++; $display("FAIL full_nwrites: got %0d want 17", wr_q.size()); end
    for (int i = 0; i < wr_q.size() && i < 17; i++) begin
      n_cmp++;
      if (wr_q[i] !== 16'hB000 + 16'(i)) begin n_bad++; $display("FAIL full_data[%0d]: got %h want %h", i, wr_q[i], 16'hB000 + 16'(i)); end
    end
    $display("full: %0d words written", wr_q.size());
    enable = 1'b0;
  endtask

  task automatic test_flush_empty();
    do_reset();
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fempty_busy0: got %b want 0", busy); end
    step();
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL fempty_busy_flush: got %b want 1", busy); end
    step();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL fempty_busy_idle: got %b want 0", busy); end
    for (int g = 0; g < 5; g++) step();
    n_cmp++; if (n_pktend != 0) begin n_bad++; $display("FAIL fempty_pktend: got %0d want 0", n_pktend); end
    $display("flush_empty: %0d pktend cycles", n_pktend);
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    mode = 1'b1; enable = 1'b1; flag_nf = 1'b1;
    for (int g = 0; g < 100 && pkt_cnt != 10'd37; g++) step();
    n_cmp++; if (pkt_cnt !== 10'd37) begin n_bad++; $display("FAIL rst_burst_reach37: got %0d want 37", pkt_cnt); end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    wr_q.delete();
    #1;
    n_cmp++; if (pkt_cnt !== 10'd0) begin n_bad++; $display("FAIL rst_burst_pkt_cnt: got %0d want 0", pkt_cnt); end
    n_cmp++; if (slwr_n !== 1'b1) begin n_bad++; $display("FAIL rst_burst_slwr_n: got %b want 1", slwr_n); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_burst_busy: got %b want 0", busy); end
    n_cmp++; if (fdata !== 16'h0000) begin n_bad++; $display("FAIL rst_burst_fdata: got %h want 0000", fdata); end
    for (int g = 0; g < 5; g++) step();
    mode = 1'b0; enable = 1'b0;
    n_cmp++; if (n_pktend != 0) begin n_bad++; $display("FAIL rst_burst_pktend: got %0d want 0", n_pktend); end
    n_cmp++;
    if (wr_q.size() == 0) begin
      n_bad++; $display("FAIL rst_burst_restart: got 0 writes want >0");
    end else if (wr_q[0] !== 16'h0000) begin
      n_bad++; $display("FAIL rst_burst_restart: got %h want 0000", wr_q[0]);
    end
    $display("reset_mid_burst: %0d writes after reset", wr_q.size());
  endtask

  initial begin
    test_reset();
    test_counter_mode();
    test_flush_partial();
    test_stall();
    test_full();
    test_flush_empty();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
